// File: rtl/sensor_poll_arbiter.sv
// sensor_poll_arbiter
//   Round-robin UART poller for NUM_SENSORS remote sensors. For each sensor it
//   sends a one-byte ID request. It then collects DATA_BYTES data bytes and a
//   CRC-8 byte (poly 0x07, init 0, MSB-first) and checks the CRC.
//   It retries on a CRC error or a byte timeout, and recovers to ID 1 after an
//   alarm frame. The last good frame is published on a 32-bit bus slave.
// Ports
//   clock, resetn                 clock, async active-low reset
//   chip_select, read, write      bus strobes
//   writedata                     [0] enable polling, [1] clear sticky flags
//   readdata                      {valid,alarm,tmo_err,crc_err,0,id,crc,data}
//   tx_data, tx_wr_en, tx_busy    uart transmit side
//   rx_data, rx_rdy, rx_rdy_clr   uart receive side
module sensor_poll_arbiter #(
    parameter int         NUM_SENSORS    = 5,
    parameter int         DATA_BYTES     = 1,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         MAX_RETRIES    = 3,
    parameter logic [7:0] ALARM_BYTE     = 8'hFF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        chip_select,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_wr_en,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_rdy_clr
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_RECV, S_CHECK, S_FAIL, S_RECOVER} state_t;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      id_q, id_d, id_next;
    logic            enable_q, enable_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      crc_q, crc_d;
    logic [15:0]     data_buf_q, data_buf_d;
    logic            cause_tmo_q, cause_tmo_d;
    logic            chk_ok_q, chk_ok_d;
    logic            chk_alarm_q, chk_alarm_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_wr_en_q, tx_wr_en_d;
    logic            rx_rdy_clr_q, rx_rdy_clr_d;
    logic            res_valid_q, res_valid_d;
    logic            res_alarm_q, res_alarm_d;
    logic            res_tmo_q, res_tmo_d;
    logic            res_crc_err_q, res_crc_err_d;
    logic [2:0]      res_id_q, res_id_d;
    logic [7:0]      res_crc_q, res_crc_d;
    logic [15:0]     res_data_q, res_data_d;

    assign id_next = (id_q == 3'(NUM_SENSORS)) ? 3'd1 : id_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        enable_d      = enable_q;
        retry_d       = retry_q;
        timer_d       = timer_q;
        byte_cnt_d    = byte_cnt_q;
        crc_d         = crc_q;
        data_buf_d    = data_buf_q;
        cause_tmo_d   = cause_tmo_q;
        chk_ok_d      = chk_ok_q;
        chk_alarm_d   = chk_alarm_q;
        tx_data_d     = tx_data_q;
        tx_wr_en_d    = 1'b0;
        rx_rdy_clr_d  = 1'b0;
        res_valid_d   = res_valid_q;
        res_alarm_d   = res_alarm_q;
        res_tmo_d     = res_tmo_q;
        res_crc_err_d = res_crc_err_q;
        res_id_d      = res_id_q;
        res_crc_d     = res_crc_q;
        res_data_d    = res_data_q;

        // Bus write comes first so that a flag set by the FSM below overrides a clear.
        if (chip_select && write) begin
            enable_d = writedata[0];
            if (writedata[1]) begin
                res_valid_d   = 1'b0;
                res_alarm_d   = 1'b0;
                res_tmo_d     = 1'b0;
                res_crc_err_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: if (enable_q) state_d = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    tx_wr_en_d = 1'b1;
                    tx_data_d  = {5'b0, id_q};
                    byte_cnt_d = 2'd0;
                    timer_d    = '0;
                    crc_d      = 8'h00;
                    data_buf_d = 16'h0000;
                    state_d    = S_RECV;
                end
            end
            S_RECV: begin
                // While the clear pulse is out, the uart still shows the old byte.
                if (rx_rdy && !rx_rdy_clr_q) begin
                    rx_rdy_clr_d = 1'b1;
                    timer_d      = '0;
                    if (byte_cnt_q < 2'(DATA_BYTES)) begin
                        crc_d      = crc8_byte(crc_q, rx_data);
                        data_buf_d = {data_buf_q[7:0], rx_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end else begin
                        // The CRC byte is judged here so that the result lands one cycle after it arrives.
                        state_d     = S_CHECK;
                        chk_ok_d    = (crc_q == rx_data);
                        chk_alarm_d = (data_buf_q[8*DATA_BYTES-1 -: 8] == ALARM_BYTE);
                        if (crc_q == rx_data) begin
                            res_id_d   = id_q;
                            res_crc_d  = crc_q;
                            res_data_d = data_buf_q;
                            if (data_buf_q[8*DATA_BYTES-1 -: 8] == ALARM_BYTE) res_alarm_d = 1'b1;
                            else                                              res_valid_d = 1'b1;
                        end else begin
                            res_crc_err_d = 1'b1;
                        end
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    cause_tmo_d = 1'b1;
                    state_d     = S_FAIL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (!chk_ok_q) begin
                    cause_tmo_d = 1'b0;
                    state_d     = S_FAIL;
                end else if (chk_alarm_q) begin
                    state_d = S_RECOVER;
                end else begin
                    retry_d = '0;
                    id_d    = id_next;
                    state_d = enable_q ? S_SEND : S_IDLE;
                end
            end
            S_FAIL: begin
                // Retries continue even if polling was disabled; only a finished sensor goes idle.
                if (retry_q < RW'(MAX_RETRIES)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_SEND;
                end else begin
                    retry_d = '0;
                    if (cause_tmo_q) res_tmo_d = 1'b1;
                    id_d    = id_next;
                    state_d = enable_q ? S_SEND : S_IDLE;
                end
            end
            S_RECOVER: begin
                id_d    = 3'd1;
                retry_d = '0;
                state_d = enable_q ? S_SEND : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            id_q          <= 3'd1;
            enable_q      <= 1'b0;
            retry_q       <= '0;
            timer_q       <= '0;
            byte_cnt_q    <= 2'd0;
            crc_q         <= 8'h00;
            data_buf_q    <= 16'h0000;
            cause_tmo_q   <= 1'b0;
            chk_ok_q      <= 1'b0;
            chk_alarm_q   <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_wr_en_q    <= 1'b0;
            rx_rdy_clr_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_alarm_q   <= 1'b0;
            res_tmo_q     <= 1'b0;
            res_crc_err_q <= 1'b0;
            res_id_q      <= 3'd0;
            res_crc_q     <= 8'h00;
            res_data_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            enable_q      <= enable_d;
            retry_q       <= retry_d;
            timer_q       <= timer_d;
            byte_cnt_q    <= byte_cnt_d;
            crc_q         <= crc_d;
            data_buf_q    <= data_buf_d;
            cause_tmo_q   <= cause_tmo_d;
            chk_ok_q      <= chk_ok_d;
            chk_alarm_q   <= chk_alarm_d;
            tx_data_q     <= tx_data_d;
            tx_wr_en_q    <= tx_wr_en_d;
            rx_rdy_clr_q  <= rx_rdy_clr_d;
            res_valid_q   <= res_valid_d;
            res_alarm_q   <= res_alarm_d;
            res_tmo_q     <= res_tmo_d;
            res_crc_err_q <= res_crc_err_d;
            res_id_q      <= res_id_d;
            res_crc_q     <= res_crc_d;
            res_data_q    <= res_data_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_wr_en   = tx_wr_en_q;
    assign rx_rdy_clr = rx_rdy_clr_q;
    assign readdata   = (chip_select && read)
                      ? {res_valid_q, res_alarm_q, res_tmo_q, res_crc_err_q, 1'b0,
                         res_id_q, res_crc_q, res_data_q}
                      : 32'h0;
endmodule

// File: tb/tb_sensor_poll_arbiter.sv
// Testbench for sensor_poll_arbiter. A uart/sensor responder issues random
// replies to each request and queues what it sent. A monitor pops that record
// at the next request and advances a frame-level reference model. It then
// compares the requested id and the published result.
module tb_sensor_poll_arbiter;
    localparam int NS = 5;
    localparam int TMO = 100;
    localparam int K_GOOD = 0, K_BAD = 1, K_TMO = 2, K_ALARM = 3;

    typedef struct {
        int         kind;
        logic [7:0] d;
    } ev_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        chip_select = 1'b1;
    logic        read = 1'b1;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_wr_en;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        rx_rdy_clr;

    sensor_poll_arbiter #(.NUM_SENSORS(NS), .DATA_BYTES(1), .TIMEOUT_CYCLES(TMO),
                          .MAX_RETRIES(3), .ALARM_BYTE(8'hFF)) dut (
        .clock(clock), .resetn(resetn), .chip_select(chip_select), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata),
        .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rdy_clr(rx_rdy_clr));

    always #5 clock = ~clock;

    int n_checks = 0, n_errors = 0, n_req = 0;
    int force_kind = -1;
    bit lat_chk = 0;
    ev_t ev_q[$];

    // Frame-level reference model
    logic [2:0]  m_id = 3'd1;
    int          m_retry = 0;
    logic [31:0] m_res = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // CRC-8 (x^8+x^2+x+1) as polynomial long division of d*x^8
    function automatic logic [7:0] ref_crc(input logic [7:0] d);
        logic [15:0] v;
        v = {d, 8'h00};
        for (int i = 15; i >= 8; i--) if (v[i]) v = v ^ (16'h0107 << (i - 8));
        return v[7:0];
    endfunction

    function automatic logic [2:0] nxt(input logic [2:0] id);
        return (int'(id) == NS) ? 3'd1 : id + 3'd1;
    endfunction

    task automatic model_fail(input bit tmo);
        if (m_retry < 3) m_retry++;
        else begin
            m_retry = 0;
            if (tmo) m_res[29] = 1'b1;
            m_id = nxt(m_id);
        end
    endtask

    task automatic model_apply(input ev_t e);
        case (e.kind)
            K_GOOD: begin
                m_res[31] = 1'b1;
                m_res[26:24] = m_id; m_res[23:16] = ref_crc(e.d); m_res[15:0] = {8'h00, e.d};
                m_retry = 0; m_id = nxt(m_id);
            end
            K_ALARM: begin
                m_res[30] = 1'b1;
                m_res[26:24] = m_id; m_res[23:16] = ref_crc(8'hFF); m_res[15:0] = 16'h00FF;
                m_retry = 0; m_id = 3'd1;
            end
            K_BAD: begin m_res[28] = 1'b1; model_fail(0); end
            default: model_fail(1);
        endcase
    endtask

    // Monitor: every request closes the previous frame in the model, then is checked.
    initial forever begin
        @(negedge clock);
        if (resetn && tx_wr_en) begin
            n_req++;
            if (ev_q.size() > 0) model_apply(ev_q.pop_front());
            chk("req_id", {24'h0, tx_data}, {24'h0, 5'b0, m_id});
            chk("req_result", readdata, m_res);
        end
    end

    // Uart transmitter stays busy for a while after each request.
    initial forever begin
        @(negedge clock);
        if (tx_wr_en) begin
            @(posedge clock); #1 tx_busy = 1'b1;
            repeat (10) @(posedge clock);
            #1 tx_busy = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit lat);
        bit seen;
        @(posedge clock); #1 rx_data = b; rx_rdy = 1'b1;
        if (lat) begin
            @(negedge clock);
            chk("latency_before", {31'h0, readdata[31]}, 32'h0);
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (rx_rdy_clr) seen = 1;
        end
        if (!seen) chk("rx_rdy_clr_seen", 32'h0, 32'h1);
        if (lat) chk("latency_after", {31'h0, readdata[31]}, 32'h1);
        @(posedge clock); #1 rx_rdy = 1'b0;
    endtask

    // Sensor responder
    initial forever begin
        @(negedge clock);
        if (resetn && tx_wr_en) begin
            ev_t e;
            int r;
            bit lat;
            #1;
            r = $urandom_range(0, 99);
            e.kind = (force_kind >= 0) ? force_kind :
                     (r < 66) ? K_GOOD : (r < 80) ? K_BAD : (r < 92) ? K_TMO : K_ALARM;
            e.d = (e.kind == K_ALARM) ? 8'hFF : 8'($urandom_range(0, 254));
            ev_q.push_back(e);
            if (e.kind != K_TMO) begin
                lat = lat_chk && (e.kind == K_GOOD);
                if (lat) lat_chk = 0;
                repeat ($urandom_range(2, 12)) @(posedge clock);
                send_byte(e.d, 0);
                repeat ($urandom_range(0, 8)) @(posedge clock);
                send_byte((e.kind == K_BAD) ? ref_crc(e.d) ^ 8'($urandom_range(1, 255))
                                            : ref_crc(e.d), lat);
            end
        end
    end

    task automatic bus_write(input logic [31:0] v);
        @(posedge clock); #1 write = 1'b1; writedata = v;
        @(posedge clock); #1 write = 1'b0; writedata = 32'h0;
    endtask

    task automatic wait_req(input int n, input int budget, input string name);
        int target;
        target = n_req + n;
        for (int i = 0; i < budget && n_req < target; i++) @(posedge clock);
        if (n_req < target) chk(name, n_req, target);
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clock);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
        chk("reset_tx_wr_en", {31'h0, tx_wr_en}, 32'h0);
        chk("reset_rx_rdy_clr", {31'h0, rx_rdy_clr}, 32'h0);
        @(posedge clock); #1 resetn = 1'b1;
        repeat (5) @(negedge clock);
        chk("idle_no_request", n_req, 0);

        // Random polling
        bus_write(32'h1);
        wait_req(60, 40000, "random_phase_timeout");

        // Disable mid-frame: the good frame in flight completes, then idle.
        force_kind = K_GOOD;
        wait_req(1, 2000, "forced_req_timeout");
        repeat (2) @(posedge clock);
        bus_write(32'h0);
        n0 = n_req;
        repeat (80) @(posedge clock);
        @(negedge clock);
        chk("disabled_no_request", n_req, n0);
        chk("disabled_frame_recorded", ev_q.size(), 1);
        if (ev_q.size() > 0) model_apply(ev_q.pop_front());
        chk("disabled_result", readdata, m_res);
        chk("valid_set", {31'h0, readdata[31]}, 32'h1);

        // Sticky flag clear, and readdata gating
        bus_write(32'h2);
        m_res[31:28] = 4'h0;
        @(negedge clock);
        chk("flags_cleared", readdata, m_res);
        @(posedge clock); #1 read = 1'b0;
        @(negedge clock);
        chk("readdata_gated", readdata, 32'h0);
        @(posedge clock); #1 read = 1'b1;

        // Re-enable and check good-frame result latency
        lat_chk = 1;
        bus_write(32'h1);
        wait_req(3, 3000, "reenable_timeout");
        chk("latency_checked", {31'h0, lat_chk}, 32'h0);
        force_kind = -1;
        wait_req(15, 15000, "random_phase2_timeout");

        // Reset during RECV
        force_kind = K_TMO;
        wait_req(1, 3000, "pre_reset_timeout");
        repeat (3) @(posedge clock);
        #1 resetn = 1'b0;
        @(negedge clock);
        chk("midframe_reset_readdata", readdata, 32'h0);
        chk("midframe_reset_tx_wr_en", {31'h0, tx_wr_en}, 32'h0);
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        ev_q.delete();
        m_id = 3'd1; m_retry = 0; m_res = 32'h0;
        force_kind = -1;
        bus_write(32'h1);
        wait_req(10, 10000, "post_reset_timeout");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
